kmeans_update_k2_d5: RTL and testbench

- Downstream of the 2-centroid, 5-dimension distance/compare pipeline.
- Consumes each propagated point (output_data0..4) together with its selected_centroid index.
- Accumulates per-centroid coordinate sums and point counts over one k-means iteration.
- When the last point arrives, computes new centroids as sum/count using a sequential divider, presents them, and pulses done.

---
 rtl/kmeans_pkg.sv | 13 +
 rtl/kmeans_update_k2_d5_if.sv | 22 ++
 rtl/kmeans_divider.sv | 61 ++++++
 rtl/kmeans_update_k2_d5.sv | 140 ++++++++++++++
 tb/tb_kmeans_update_k2_d5.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared constants, FSM state type and width helper for the k-means update block.
package kmeans_pkg;
  localparam int K = 2;
  localparam int D = 5;
  localparam int NDIV = K * D;
  localparam int DIV_K0_FIRST = 0;
  localparam int DIV_K1_FIRST = D;
  localparam int DIV_LAST = NDIV - 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_e;
  function automatic int sum_width(input int dw, input int cw);
    return dw + cw;
  endfunction
endpackage

// File: rtl/kmeans_update_k2_d5_if.sv
// kmeans_update_k2_d5_if: point stream in, centroid registers and status out.
interface kmeans_update_k2_d5_if #(parameter int DW = 16) ();
  logic start, in_valid, in_last, in_sel;
  logic [DW-1:0] input_data0, input_data1, input_data2, input_data3, input_data4;
  logic [DW-1:0] centroid0_d0, centroid0_d1, centroid0_d2, centroid0_d3, centroid0_d4;
  logic [DW-1:0] centroid1_d0, centroid1_d1, centroid1_d2, centroid1_d3, centroid1_d4;
  logic busy, done, overflow, converged;
  modport master (
    output start, in_valid, in_last, in_sel,
    output input_data0, input_data1, input_data2, input_data3, input_data4,
    input centroid0_d0, centroid0_d1, centroid0_d2, centroid0_d3, centroid0_d4,
    input centroid1_d0, centroid1_d1, centroid1_d2, centroid1_d3, centroid1_d4,
    input busy, done, overflow, converged
  );
  modport slave (
    input start, in_valid, in_last, in_sel,
    input input_data0, input_data1, input_data2, input_data3, input_data4,
    output centroid0_d0, centroid0_d1, centroid0_d2, centroid0_d3, centroid0_d4,
    output centroid1_d0, centroid1_d1, centroid1_d2, centroid1_d3, centroid1_d4,
    output busy, done, overflow, converged
  );
endinterface

// File: rtl/kmeans_divider.sv
// kmeans_divider: restoring unsigned divider, 1 load cycle + SUM_W iterations; divisor 0 gives all ones.
module kmeans_divider #(parameter int SUM_W = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [SUM_W-1:0] quotient
);
  localparam int CNT_W = $clog2(SUM_W + 1);
  logic [SUM_W-1:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, valid_q, valid_d;
  logic [SUM_W:0] sh;
  logic ge;
  assign sh = {rem_q, quo_q[SUM_W-1]};
  assign ge = sh >= {1'b0, den_q};
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    den_d = den_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    valid_d = 1'b0;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      den_d = divisor;
      cnt_d = CNT_W'(SUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? SUM_W'(sh - {1'b0, den_q}) : sh[SUM_W-1:0];
      quo_d = {quo_q[SUM_W-2:0], ge};
      cnt_d = cnt_q - 1'b1;
      busy_d = cnt_q != CNT_W'(1);
      valid_d = cnt_q == CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign busy = busy_q;
  assign valid = valid_q;
  assign quotient = quo_q;
endmodule

// File: rtl/kmeans_update_k2_d5.sv
// kmeans_update_k2_d5: accumulates per-centroid sums/counts, then updates centroids as sum/count.
// Optional KMEANS_UPDATE_CONVERGE_EN adds a registered converged flag.
module kmeans_update_k2_d5
  import kmeans_pkg::*;
#(
  parameter int input_data_width = 16,
  parameter int count_width = 16
) (
  input logic clk,
  input logic rst_n,
  kmeans_update_k2_d5_if.slave bus
);
  localparam int DW = input_data_width;
  localparam int CW = count_width;
  localparam int SW = sum_width(DW, CW);
  localparam int IW = $clog2(NDIV);
  state_e state_q, state_d;
  logic [SW-1:0] sum_q [NDIV];
  logic [SW-1:0] sum_d [NDIV];
  logic [DW-1:0] cen_q [NDIV];
  logic [DW-1:0] cen_d [NDIV];
  logic [CW-1:0] cnt_q [K];
  logic [CW-1:0] cnt_d [K];
  logic [DW-1:0] dat [D];
  logic [IW-1:0] idx_q, idx_d;
  logic ovf_q, ovf_d;
  logic acc, go, sel_k, last_div;
  logic dv_start, dv_busy, dv_valid;
  logic [SW-1:0] dv_quo;
  logic quo_unused;
  assign dat = '{bus.input_data0, bus.input_data1, bus.input_data2, bus.input_data3, bus.input_data4};
  assign go = state_q == IDLE && bus.start;
  assign acc = state_q == ACCUM && bus.in_valid;
  assign sel_k = idx_q >= IW'(DIV_K1_FIRST);
  assign last_div = idx_q == IW'(DIV_LAST);
  // Next division loads on the same edge the previous quotient is written.
  assign dv_start = state_q == DIV && !dv_busy && !(dv_valid && last_div);
  assign quo_unused = |dv_quo[SW-1:DW];
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = ACCUM;
      ACCUM: if (acc && bus.in_last) state_d = DIV;
      DIV: if (dv_valid && last_div) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    cen_d = cen_q;
    idx_d = idx_q;
    ovf_d = ovf_q;
    if (go) begin
      for (int i = 0; i < NDIV; i++) sum_d[i] = '0;
      for (int k = 0; k < K; k++) cnt_d[k] = '0;
      ovf_d = 1'b0;
    end
    if (acc) begin
      if (&cnt_q[bus.in_sel]) ovf_d = 1'b1;
      else begin
        cnt_d[bus.in_sel] = cnt_q[bus.in_sel] + 1'b1;
        for (int i = 0; i < NDIV; i++)
          if ((i >= DIV_K1_FIRST) == bus.in_sel) sum_d[i] = sum_q[i] + SW'(dat[i % D]);
      end
    end
    if (state_q == ACCUM) idx_d = IW'(DIV_K0_FIRST);
    if (dv_valid) begin
      idx_d = idx_q + 1'b1;
      if (cnt_q[sel_k] != '0) cen_d[idx_q] = dv_quo[DW-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < NDIV; i++) begin
        sum_q[i] <= '0;
        cen_q[i] <= '0;
      end
      for (int k = 0; k < K; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
      sum_q <= sum_d;
      cen_q <= cen_d;
      cnt_q <= cnt_d;
    end
  end
  kmeans_divider #(.SUM_W(SW)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(dv_start),
    .dividend(sum_q[idx_d]),
    .divisor(SW'(cnt_q[idx_d >= IW'(DIV_K1_FIRST)])),
    .busy(dv_busy),
    .valid(dv_valid),
    .quotient(dv_quo)
  );
`ifdef KMEANS_UPDATE_CONVERGE_EN
  logic eq_q, eq_d, conv_q, conv_d;
  always_comb begin
    eq_d = eq_q;
    conv_d = conv_q;
    if (go) begin
      eq_d = 1'b1;
      conv_d = 1'b0;
    end
    if (dv_valid && cnt_q[sel_k] != '0 && dv_quo[DW-1:0] != cen_q[idx_q]) eq_d = 1'b0;
    if (dv_valid && last_div) conv_d = eq_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q <= 1'b0;
      conv_q <= 1'b0;
    end else begin
      eq_q <= eq_d;
      conv_q <= conv_d;
    end
  end
  assign bus.converged = conv_q;
`else
  assign bus.converged = 1'b0;
`endif
  assign bus.busy = state_q == ACCUM || state_q == DIV;
  assign bus.done = state_q == DONE;
  assign bus.overflow = ovf_q;
  assign bus.centroid0_d0 = cen_q[0];
  assign bus.centroid0_d1 = cen_q[1];
  assign bus.centroid0_d2 = cen_q[2];
  assign bus.centroid0_d3 = cen_q[3];
  assign bus.centroid0_d4 = cen_q[4];
  assign bus.centroid1_d0 = cen_q[5];
  assign bus.centroid1_d1 = cen_q[6];
  assign bus.centroid1_d2 = cen_q[7];
  assign bus.centroid1_d3 = cen_q[8];
  assign bus.centroid1_d4 = cen_q[9];
endmodule

// File: tb/tb_kmeans_update_k2_d5.sv
// tb_kmeans_update_k2_d5: directed vectors against the default build and a count_width=2 build.
module tb_kmeans_update_k2_d5;
  logic clk, rst_n;
  int total = 0, bad = 0;
  kmeans_update_k2_d5_if #(.DW(16)) b0 ();
  kmeans_update_k2_d5_if #(.DW(16)) b1 ();
  kmeans_update_k2_d5 u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  kmeans_update_k2_d5 #(.input_data_width(16), .count_width(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic go0();
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
  endtask
  task automatic pt(input logic sel, input logic last, input logic [15:0] a, b, c, d, e);
    b0.in_valid = 1'b1;
    b0.in_last = last;
    b0.in_sel = sel;
    b0.input_data0 = a;
    b0.input_data1 = b;
    b0.input_data2 = c;
    b0.input_data3 = d;
    b0.input_data4 = e;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.in_last = 1'b0;
  endtask
  task automatic wait_done(input bit u, input int lat, input string tag);
    int n = 0;
    while (!(u ? b1.done : b0.done) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, lat);
  endtask
  initial begin
    int seen;
    rst_n = 1'b0;
    {b0.start, b0.in_valid, b0.in_last, b0.in_sel} = '0;
    {b1.start, b1.in_valid, b1.in_last, b1.in_sel} = '0;
    {b0.input_data0, b0.input_data1, b0.input_data2, b0.input_data3, b0.input_data4} = '0;
    {b1.input_data0, b1.input_data1, b1.input_data2, b1.input_data3, b1.input_data4} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_c0d0", b0.centroid0_d0, 0);
    check("rst_busy", b0.busy, 0);
    check("rst_done", b0.done, 0);
    check("rst_ovf", b0.overflow, 0);
    check("rst_conv", b0.converged, 0);
    go0();
    pt(0, 0, 2, 4, 6, 8, 10);
    pt(0, 1, 4, 6, 8, 10, 12);
    check("t1_busy", b0.busy, 1);
    wait_done(0, 331, "t1_lat");
    check("t1_c0d0", b0.centroid0_d0, 3);
    check("t1_c0d1", b0.centroid0_d1, 5);
    check("t1_c0d2", b0.centroid0_d2, 7);
    check("t1_c0d3", b0.centroid0_d3, 9);
    check("t1_c0d4", b0.centroid0_d4, 11);
    check("t1_c1d0", b0.centroid1_d0, 0);
    check("t1_conv", b0.converged, 0);
    @(negedge clk);
    check("t1_pulse", b0.done, 0);
    check("t1_idle", b0.busy, 0);
    go0();
    pt(1, 0, 10, 0, 0, 0, 0);
    pt(1, 0, 11, 0, 0, 0, 0);
    pt(1, 1, 11, 0, 0, 0, 0);
    wait_done(0, 331, "t2_lat");
    check("t2_c1d0", b0.centroid1_d0, 10);
    check("t2_c1d1", b0.centroid1_d1, 0);
    check("t2_c0d0_held", b0.centroid0_d0, 3);
    @(negedge clk);
    b0.start = 1'b1;
    b0.in_valid = 1'b1;
    b0.in_sel = 1'b1;
    b0.input_data0 = 100;
    b0.input_data1 = 100;
    @(negedge clk);
    b0.start = 1'b0;
    b0.in_valid = 1'b0;
    pt(1, 0, 20, 7, 0, 0, 0);
    b0.start = 1'b1;
    b0.in_last = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    b0.in_last = 1'b0;
    check("t3_still_accum", b0.busy, 1);
    pt(1, 1, 30, 9, 0, 0, 0);
    wait_done(0, 331, "t3_lat");
    check("t3_c1d0", b0.centroid1_d0, 25);
    check("t3_c1d1", b0.centroid1_d1, 8);
    check("t3_c0d0_held", b0.centroid0_d0, 3);
    @(negedge clk);
    go0();
    pt(0, 1, 8, 8, 8, 8, 8);
    repeat (100) @(negedge clk);
    check("t5_mid_div", b0.busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", b0.busy, 0);
    check("t5_rst_c0d0", b0.centroid0_d0, 0);
    check("t5_rst_c1d0", b0.centroid1_d0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (400) begin
      @(negedge clk);
      seen |= int'(b0.done);
    end
    check("t5_no_done", seen, 0);
    go0();
    pt(0, 0, 2, 4, 6, 8, 10);
    pt(0, 1, 4, 6, 8, 10, 12);
    wait_done(0, 331, "t5_lat");
    check("t5_c0d0", b0.centroid0_d0, 3);
    check("t5_c0d4", b0.centroid0_d4, 11);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b1.in_valid = 1'b1;
      b1.in_sel = 1'b0;
      b1.in_last = i == 4;
      b1.input_data0 = 1;
      @(negedge clk);
      b1.in_valid = 1'b0;
      b1.in_last = 1'b0;
      if (i == 2) check("t4_ovf_3", b1.overflow, 0);
      if (i == 3) check("t4_ovf_4", b1.overflow, 1);
    end
    wait_done(1, 191, "t4_lat");
    check("t4_c0d0", b1.centroid0_d0, 1);
    check("t4_ovf_sticky", b1.overflow, 1);
    @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    check("t4_ovf_clr", b1.overflow, 0);
`ifdef KMEANS_UPDATE_CONVERGE_EN
    @(negedge clk);
    go0();
    pt(0, 1, 3, 5, 7, 9, 11);
    wait_done(0, 331, "t6_lat_a");
    check("t6_conv_a", b0.converged, 1);
    @(negedge clk);
    check("t6_conv_hold", b0.converged, 1);
    go0();
    pt(0, 1, 3, 5, 7, 9, 12);
    wait_done(0, 331, "t6_lat_b");
    check("t6_conv_b", b0.converged, 0);
    check("t6_c0d4", b0.centroid0_d4, 12);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
